// File: rtl/ptp_txegr_ts_collector.sv
// PTP TX egress timestamp collector: matches MAC egress timestamps to in-order pending requests.
// Optional statistics counters are built when PTP_TS_COLLECTOR_STATS_EN is defined; otherwise they read 0.
module ptp_txegr_ts_collector #(
  parameter int FP_W        = 20,
  parameter int TS_W        = 96,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic [FP_W-1:0]          req_fp,
  output logic                     req_ready,
  input  logic                     ts_valid,
  input  logic [FP_W-1:0]          ts_fp,
  input  logic [TS_W-1:0]          ts_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FP_W-1:0]          out_fp,
  output logic [TS_W-1:0]          out_ts,
  output logic [1:0]               out_status,
  output logic [$clog2(DEPTH):0]   pend_cnt,
  output logic [15:0]              cnt_ok,
  output logic [15:0]              cnt_timeout,
  output logic [15:0]              cnt_unmatched,
  output logic [15:0]              cnt_drop
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_TIMEOUT   = 2'd1;
  localparam logic [1:0] ST_UNMATCHED = 2'd2;

  typedef enum logic {S_EMPTY, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [FP_W-1:0]   r_q [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_cnt;
  logic [TMR_W-1:0]  r_timer;
  logic              r_out_vld;
  logic [FP_W-1:0]   r_out_fp;
  logic [TS_W-1:0]   r_out_ts;
  logic [1:0]        r_out_status;

  logic              w_push;
  logic              w_pop;
  logic              w_match;
  logic              w_tmo;
  logic              w_unm;
  logic              w_res_vld;
  logic [FP_W-1:0]   w_res_fp;
  logic [TS_W-1:0]   w_res_ts;
  logic [1:0]        w_res_status;
  logic              w_free;
  logic              w_load;
  logic [FP_W-1:0]   w_head_fp;

  assign req_ready  = (r_cnt != CW'(DEPTH));
  assign pend_cnt   = r_cnt;
  assign out_valid  = r_out_vld;
  assign out_fp     = r_out_fp;
  assign out_ts     = r_out_ts;
  assign out_status = r_out_status;
  assign w_head_fp  = r_q[r_rptr];
  assign w_push     = req_valid && req_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_match     = 1'b0;
    w_tmo       = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_push) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_match = ts_valid && (ts_fp == w_head_fp);
        w_tmo   = !w_match && (r_timer == TMR_W'(TIMEOUT_CYC - 1));
        w_pop   = w_match || w_tmo;
        if (w_pop && !w_push && (r_cnt == CW'(1))) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  assign w_unm = ts_valid && !w_match;

  // Priority: match, then timeout (a concurrent stray return is dropped), then stray return.
  always_comb begin
    w_res_vld    = 1'b0;
    w_res_fp     = '0;
    w_res_ts     = '0;
    w_res_status = ST_OK;
    if (w_match) begin
      w_res_vld = 1'b1;
      w_res_fp  = ts_fp;
      w_res_ts  = ts_data;
    end else if (w_tmo) begin
      w_res_vld    = 1'b1;
      w_res_fp     = w_head_fp;
      w_res_status = ST_TIMEOUT;
    end else if (w_unm) begin
      w_res_vld    = 1'b1;
      w_res_fp     = ts_fp;
      w_res_ts     = ts_data;
      w_res_status = ST_UNMATCHED;
    end
  end

  assign w_free = !r_out_vld || out_ready;
  assign w_load = w_res_vld && w_free;

  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wptr] <= req_fp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_cnt        <= '0;
      r_timer      <= '0;
      r_out_vld    <= 1'b0;
      r_out_fp     <= '0;
      r_out_ts     <= '0;
      r_out_status <= ST_OK;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
      if (w_pop)                 r_timer <= '0;
      else if (r_state == S_WAIT) r_timer <= r_timer + TMR_W'(1);
      if (w_load) begin
        r_out_vld    <= 1'b1;
        r_out_fp     <= w_res_fp;
        r_out_ts     <= w_res_ts;
        r_out_status <= w_res_status;
      end else if (out_ready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

`ifdef PTP_TS_COLLECTOR_STATS_EN
  logic [15:0] r_cnt_ok;
  logic [15:0] r_cnt_timeout;
  logic [15:0] r_cnt_unmatched;
  logic [15:0] r_cnt_drop;
  logic [1:0]  w_drop_n;

  // A stray return shadowed by a timeout and a result blocked by a full output can both drop in one cycle.
  assign w_drop_n = {1'b0, (w_res_vld && !w_free)} + {1'b0, (w_tmo && w_unm)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_ok        <= '0;
      r_cnt_timeout   <= '0;
      r_cnt_unmatched <= '0;
      r_cnt_drop      <= '0;
    end else begin
      if (w_match && (r_cnt_ok != 16'hFFFF))             r_cnt_ok <= r_cnt_ok + 16'd1;
      if (w_tmo && (r_cnt_timeout != 16'hFFFF))          r_cnt_timeout <= r_cnt_timeout + 16'd1;
      if (w_unm && !w_tmo && (r_cnt_unmatched != 16'hFFFF))
        r_cnt_unmatched <= r_cnt_unmatched + 16'd1;
      if ({1'b0, r_cnt_drop} + {15'd0, w_drop_n} > 17'h0FFFF) r_cnt_drop <= 16'hFFFF;
      else r_cnt_drop <= r_cnt_drop + {14'd0, w_drop_n};
    end
  end

  assign cnt_ok        = r_cnt_ok;
  assign cnt_timeout   = r_cnt_timeout;
  assign cnt_unmatched = r_cnt_unmatched;
  assign cnt_drop      = r_cnt_drop;
`else
  assign cnt_ok        = 16'd0;
  assign cnt_timeout   = 16'd0;
  assign cnt_unmatched = 16'd0;
  assign cnt_drop      = 16'd0;
`endif

endmodule

// File: tb/tb_ptp_txegr_ts_collector.sv
// Randomized scoreboard bench for ptp_txegr_ts_collector: a queue-based reference model predicts
// each cycle's results; a negedge monitor compares DUT outputs against the model and scoreboard.
module tb_ptp_txegr_ts_collector;
  localparam int FP_W  = 20;
  localparam int TS_W  = 96;
  localparam int DEPTH = 8;
  localparam int TMO   = 64;

  typedef struct {
    logic [FP_W-1:0] fp;
    logic [TS_W-1:0] ts;
    logic [1:0]      st;
  } res_t;

  logic              clk, rst_n;
  logic              req_valid, req_ready, ts_valid, out_valid, out_ready;
  logic [FP_W-1:0]   req_fp, ts_fp, out_fp;
  logic [TS_W-1:0]   ts_data, out_ts;
  logic [1:0]        out_status;
  logic [$clog2(DEPTH):0] pend_cnt;
  logic [15:0]       cnt_ok, cnt_timeout, cnt_unmatched, cnt_drop;

  int checks = 0;
  int errors = 0;

  ptp_txegr_ts_collector #(.FP_W(FP_W), .TS_W(TS_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_fp(req_fp), .req_ready(req_ready),
    .ts_valid(ts_valid), .ts_fp(ts_fp), .ts_data(ts_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp), .out_ts(out_ts),
    .out_status(out_status), .pend_cnt(pend_cnt),
    .cnt_ok(cnt_ok), .cnt_timeout(cnt_timeout), .cnt_unmatched(cnt_unmatched), .cnt_drop(cnt_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int n);
    return (c + n > 65535) ? 65535 : c + n;
  endfunction

  // Reference model: pending fingerprints, head age, one-slot output holder, expected results.
  logic [FP_W-1:0] mq[$];
  res_t            sb[$];
  int              m_age, m_ok, m_tmo, m_unm, m_drop;
  bit              m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); sb.delete();
      m_age = 0; m_busy = 0;
      m_ok = 0; m_tmo = 0; m_unm = 0; m_drop = 0;
    end else begin
      bit   push, match, tmo, stray, has_res, free;
      res_t r;
      push    = req_valid && (mq.size() < DEPTH);
      match   = ts_valid && (mq.size() > 0) && (ts_fp == mq[0]);
      tmo     = (mq.size() > 0) && !match && (m_age == TMO - 1);
      stray   = ts_valid && !match;
      has_res = match || tmo || stray;
      if (match)    r = '{fp: ts_fp, ts: ts_data, st: 2'd0};
      else if (tmo) r = '{fp: mq[0], ts: '0, st: 2'd1};
      else          r = '{fp: ts_fp, ts: ts_data, st: 2'd2};
      free = !m_busy || out_ready;
      if (m_busy && out_ready) begin
        void'(sb.pop_front());
        m_busy = 0;
      end
      if (has_res && free) begin
        sb.push_back(r);
        m_busy = 1;
      end
`ifdef PTP_TS_COLLECTOR_STATS_EN
      if (match) m_ok = sat(m_ok, 1);
      if (tmo) m_tmo = sat(m_tmo, 1);
      if (stray && !tmo) m_unm = sat(m_unm, 1);
      m_drop = sat(m_drop, int'(has_res && !free) + int'(tmo && stray));
`endif
      if (match || tmo) begin
        void'(mq.pop_front());
        m_age = 0;
      end else if (mq.size() > 0) begin
        m_age++;
      end
      if (push) mq.push_back(req_fp);
    end
  end

  // Monitor: compares outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pend_cnt", 128'(pend_cnt), 128'(mq.size()));
      chk("req_ready", 128'(req_ready), 128'(mq.size() != DEPTH));
      chk("out_valid", 128'(out_valid), 128'(m_busy));
      if (out_valid && m_busy) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 128'(0), 128'(1));
        end else begin
          chk("out_fp", 128'(out_fp), 128'(sb[0].fp));
          chk("out_ts", 128'(out_ts), 128'(sb[0].ts));
          chk("out_status", 128'(out_status), 128'(sb[0].st));
        end
      end
      chk("cnt_ok", 128'(cnt_ok), 128'(m_ok));
      chk("cnt_timeout", 128'(cnt_timeout), 128'(m_tmo));
      chk("cnt_unmatched", 128'(cnt_unmatched), 128'(m_unm));
      chk("cnt_drop", 128'(cnt_drop), 128'(m_drop));
    end
  end

  task automatic drive(input bit rv, input logic [FP_W-1:0] rfp, input bit tv,
                       input logic [FP_W-1:0] tfp, input bit ordy);
    @(negedge clk);
    req_valid = rv;
    req_fp    = rfp;
    ts_valid  = tv;
    ts_fp     = tfp;
    ts_data   = {$urandom, $urandom, $urandom};
    out_ready = ordy;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(0, '0, 0, '0, ordy);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_out_fp"}, 128'(out_fp), 128'(0));
    chk({tag, "_out_ts"}, 128'(out_ts), 128'(0));
    chk({tag, "_out_status"}, 128'(out_status), 128'(0));
    chk({tag, "_pend_cnt"}, 128'(pend_cnt), 128'(0));
    chk({tag, "_cnt_sum"}, 128'(cnt_ok | cnt_timeout | cnt_unmatched | cnt_drop), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 0; req_fp = '0; ts_valid = 0; ts_fp = '0; ts_data = '0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst0");
    #2 rst_n = 1'b1;
    #1 chk("rst0_req_ready", 128'(req_ready), 128'(1));

    // In-order matches streaming back to back.
    drive(1, 20'h00011, 0, '0, 1);
    drive(1, 20'h00022, 0, '0, 1);
    drive(0, '0, 1, 20'h00011, 1);
    drive(0, '0, 1, 20'h00022, 1);
    idle(3, 1);

    // Timeout of a lone head.
    drive(1, 20'h00033, 0, '0, 1);
    idle(TMO + 5, 1);

    // Stray return leaves the head in place, then the real return.
    drive(1, 20'h00044, 0, '0, 1);
    drive(0, '0, 1, 20'h00055, 1);
    drive(0, '0, 1, 20'h00044, 1);
    idle(2, 1);

    // Fill to DEPTH, then pop the head while a request is waiting.
    for (int i = 0; i < DEPTH; i++) drive(1, FP_W'(20'h00100 + i), 0, '0, 1);
    drive(1, 20'h00200, 0, '0, 1);
    drive(1, 20'h00201, 1, 20'h00100, 1);
    drive(0, '0, 0, '0, 1);
    for (int i = 1; i < DEPTH; i++) drive(0, '0, 1, FP_W'(20'h00100 + i), 1);
    drive(0, '0, 1, 20'h00201, 1);
    idle(2, 1);

    // Output blocked: second result dropped, both entries still popped.
    drive(1, 20'h00301, 0, '0, 0);
    drive(1, 20'h00302, 0, '0, 0);
    drive(0, '0, 1, 20'h00301, 0);
    drive(0, '0, 1, 20'h00302, 0);
    idle(3, 0);
    idle(2, 1);

    // Random traffic with frequent returns.
    for (int i = 0; i < 2000; i++) begin
      logic [FP_W-1:0] tf;
      tf = (mq.size() > 0 && ($urandom % 4 != 0)) ? mq[0] : FP_W'($urandom % 8);
      drive(($urandom % 3) == 0, FP_W'($urandom % 16), ($urandom % 4) == 0, tf, ($urandom % 4) != 0);
    end
    // Random traffic with sparse returns so timeouts collide with strays and blocked output.
    for (int i = 0; i < 1500; i++) begin
      logic [FP_W-1:0] tf;
      tf = (mq.size() > 0 && ($urandom % 2 == 0)) ? mq[0] : FP_W'($urandom % 8);
      drive(($urandom % 8) == 0, FP_W'($urandom % 16), ($urandom % 40) == 0, tf, ($urandom % 3) != 0);
    end
    idle(TMO * 2, 1);

    // Reset mid-transaction with pending entries and a held result.
    drive(1, 20'h00401, 0, '0, 0);
    drive(1, 20'h00402, 0, '0, 0);
    drive(1, 20'h00403, 0, '0, 0);
    drive(0, '0, 1, 20'h00777, 0);
    drive(0, '0, 0, '0, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("rst1");
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("rst1_req_ready", 128'(req_ready), 128'(1));
    idle(TMO + 10, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
